mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_rsp_pkg.sv | 15 +
 rtl/mem_wbuf.sv | 65 ++++++
 rtl/mem_responder.sv | 104 ++++++++++
 tb/tb_mem_responder.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_rsp_pkg.sv
// Shared widths, default sizing and the write-buffer entry layout for the
// memory responder and its write buffer.
package mem_rsp_pkg;

  localparam int DATA_W       = 16;
  localparam int ADDR_W       = 16;
  localparam int DEF_RD_LAT   = 2;
  localparam int DEF_WB_DEPTH = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/mem_wbuf.sv
// Write buffer: circular FIFO of {addr, data} entries plus a lookup that
// returns the youngest entry whose address matches.
module mem_wbuf
  import mem_rsp_pkg::*;
#(
  parameter int DEPTH = DEF_WB_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  wb_entry_t         push_entry,
  input  logic              pop,
  output wb_entry_t         head,
  output logic              empty,
  output logic              full,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              hit,
  output logic [DATA_W-1:0] hit_data
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_entry_t     entries [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;

  assign empty = (count == '0);
  assign full  = (count == (PW+1)'(DEPTH));
  assign head  = entries[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) entries[wr_ptr] <= push_entry;
  end

  // Scan oldest to youngest so the last match seen is the youngest.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i < int'(count) && entries[rd_ptr + PW'(i)].addr == lookup_addr) begin
        hit      = 1'b1;
        hit_data = entries[rd_ptr + PW'(i)].data;
      end
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory responder: single-port word array fronted by a write buffer that
// drains when reads leave the port free; reads forward from the buffer.
module mem_responder
  import mem_rsp_pkg::*;
#(
  parameter int MEM_AW   = 10,
  parameter int RD_LAT   = DEF_RD_LAT,
  parameter int WB_DEPTH = DEF_WB_DEPTH
) (
  input  logic              Clk1,
  input  logic              Reset_l,
  input  logic [ADDR_W-1:0] Addr,
  input  logic              RD,
  input  logic              WR,
  input  logic [DATA_W-1:0] DataIn,
  output logic [DATA_W-1:0] DataOut,
  output logic              DValid,
  output logic              Busy,
  output logic              Ovf,
  output logic              Err
);

  wb_entry_t         wb_head;
  wb_entry_t         wb_new;
  logic              wb_empty;
  logic              wb_full;
  logic              wb_hit;
  logic [DATA_W-1:0] wb_hit_data;
  logic [ADDR_W-1:0] addr_m;
  logic              do_push;
  logic              do_drain;
  logic              unused_bits;

  logic [DATA_W-1:0] mem_array [2**MEM_AW];
  logic [DATA_W-1:0] arr_q;
  logic              fwd_hit_q;
  logic [RD_LAT-1:0] vld_q;
  logic [DATA_W-1:0] dat_q     [RD_LAT];
  logic [DATA_W-1:0] stage_dat [RD_LAT];

  assign addr_m      = ADDR_W'(Addr[MEM_AW-1:0]);
  assign wb_new      = '{addr: addr_m, data: DataIn};
  assign unused_bits = ^{Addr, wb_head.addr};

  // A plain write only enqueues; a write into a full buffer with the port
  // free drains one entry in the same cycle so nothing is lost.
  assign do_push  = WR & ~RD;
  assign do_drain = ~RD & ~wb_empty & (~WR | wb_full);
  assign Busy     = ~wb_empty;

  mem_wbuf #(
    .DEPTH (WB_DEPTH)
  ) u_wbuf (
    .clk         (Clk1),
    .rst_n       (Reset_l),
    .push        (do_push),
    .push_entry  (wb_new),
    .pop         (do_drain),
    .head        (wb_head),
    .empty       (wb_empty),
    .full        (wb_full),
    .lookup_addr (addr_m),
    .hit         (wb_hit),
    .hit_data    (wb_hit_data)
  );

  // Array contents survive reset.
  always_ff @(posedge Clk1) begin
    if (do_drain) mem_array[wb_head.addr[MEM_AW-1:0]] <= wb_head.data;
    arr_q <= mem_array[Addr[MEM_AW-1:0]];
  end

  always_comb begin
    for (int k = 0; k < RD_LAT; k++) stage_dat[k] = dat_q[k];
    stage_dat[0] = fwd_hit_q ? dat_q[0] : arr_q;
  end

  always_ff @(posedge Clk1 or negedge Reset_l) begin
    if (!Reset_l) begin
      vld_q     <= '0;
      fwd_hit_q <= 1'b0;
      for (int k = 0; k < RD_LAT; k++) dat_q[k] <= '0;
      DataOut   <= '0;
      DValid    <= 1'b0;
      Ovf       <= 1'b0;
      Err       <= 1'b0;
    end else begin
      vld_q[0]  <= RD;
      fwd_hit_q <= wb_hit;
      dat_q[0]  <= wb_hit_data;
      for (int k = 1; k < RD_LAT; k++) begin
        vld_q[k] <= vld_q[k-1];
        dat_q[k] <= stage_dat[k-1];
      end
      DValid <= vld_q[RD_LAT-1];
      if (vld_q[RD_LAT-1]) DataOut <= stage_dat[RD_LAT-1];
      if (RD && WR) begin
        Err <= 1'b1;
        if (wb_full) Ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed scenarios plus random traffic, checked
// against a queue-based reference model of the buffer and array.
module tb_mem_responder;
  import mem_rsp_pkg::*;

  localparam int MEM_AW   = 10;
  localparam int RD_LAT   = 2;
  localparam int WB_DEPTH = 4;

  logic        Clk1 = 1'b0;
  logic        Reset_l = 1'b0;
  logic [15:0] Addr = '0;
  logic        RD = 1'b0;
  logic        WR = 1'b0;
  logic [15:0] DataIn = '0;
  logic [15:0] DataOut;
  logic        DValid;
  logic        Busy;
  logic        Ovf;
  logic        Err;

  always #5 Clk1 = ~Clk1;

  mem_responder #(
    .MEM_AW   (MEM_AW),
    .RD_LAT   (RD_LAT),
    .WB_DEPTH (WB_DEPTH)
  ) dut (
    .Clk1    (Clk1),
    .Reset_l (Reset_l),
    .Addr    (Addr),
    .RD      (RD),
    .WR      (WR),
    .DataIn  (DataIn),
    .DataOut (DataOut),
    .DValid  (DValid),
    .Busy    (Busy),
    .Ovf     (Ovf),
    .Err     (Err)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] d;
  } ent_t;

  typedef struct {
    int          due;
    logic [15:0] d;
  } rd_t;

  logic [15:0] m_mem [1024];
  ent_t        m_buf [$];
  rd_t         m_rd  [$];
  int          cyc;
  logic        m_ovf;
  logic        m_err;
  logic        m_dv;
  logic [15:0] m_dout;
  int          checks;
  int          errors;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] m_lookup(input logic [15:0] a);
    for (int i = m_buf.size() - 1; i >= 0; i--)
      if (m_buf[i].a == a) return m_buf[i].d;
    return m_mem[a[9:0]];
  endfunction

  function automatic void m_drain();
    ent_t e;
    e = m_buf.pop_front();
    m_mem[e.a[9:0]] = e.d;
  endfunction

  // One clock of traffic: drive, apply the behavioural rules, then compare.
  task automatic cycle(input logic rd, input logic wr, input logic [15:0] addr,
                       input logic [15:0] din);
    logic [15:0] a;
    rd_t         r;
    RD = rd; WR = wr; Addr = addr; DataIn = din;
    @(posedge Clk1);
    cyc++;
    a = addr & 16'h03FF;
    if (rd) begin
      r.due = cyc + RD_LAT;
      r.d   = m_lookup(a);
      m_rd.push_back(r);
    end
    if (rd && wr) begin
      m_err = 1'b1;
      if (m_buf.size() == WB_DEPTH) m_ovf = 1'b1;
    end else if (wr) begin
      if (m_buf.size() == WB_DEPTH) m_drain();
      m_buf.push_back('{a: a, d: din});
    end else if (!rd && m_buf.size() > 0) begin
      m_drain();
    end
    m_dv = 1'b0;
    if (m_rd.size() > 0 && m_rd[0].due == cyc) begin
      m_dv   = 1'b1;
      m_dout = m_rd[0].d;
      void'(m_rd.pop_front());
    end
    #1;
    check("dvalid", 16'(DValid), 16'(m_dv));
    check("dataout", DataOut, m_dout);
    check("busy", 16'(Busy), 16'(m_buf.size() != 0));
    check("ovf", 16'(Ovf), 16'(m_ovf));
    check("err", 16'(Err), 16'(m_err));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic do_reset();
    RD = 1'b0; WR = 1'b0;
    #2 Reset_l = 1'b0;
    #1;
    check("rst_dataout", DataOut, 16'h0000);
    check("rst_dvalid", 16'(DValid), 16'h0000);
    check("rst_busy", 16'(Busy), 16'h0000);
    check("rst_ovf", 16'(Ovf), 16'h0000);
    check("rst_err", 16'(Err), 16'h0000);
    m_buf.delete();
    m_rd.delete();
    m_ovf  = 1'b0;
    m_err  = 1'b0;
    m_dout = '0;
    @(posedge Clk1);
    @(posedge Clk1);
    #1;
    check("rst_hold_dvalid", 16'(DValid), 16'h0000);
    #2 Reset_l = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d;
    logic [15:0] a;
    int          r;
    checks = 0; errors = 0; cyc = 0;
    m_ovf = 1'b0; m_err = 1'b0; m_dout = '0; m_dv = 1'b0;

    // Reset state
    repeat (2) @(posedge Clk1);
    #1;
    check("init_dataout", DataOut, 16'h0000);
    check("init_dvalid", 16'(DValid), 16'h0000);
    check("init_busy", 16'(Busy), 16'h0000);
    check("init_ovf", 16'(Ovf), 16'h0000);
    check("init_err", 16'(Err), 16'h0000);
    #2 Reset_l = 1'b1;

    // Preload words 0..63 through the write path
    for (int i = 0; i < 64; i++) begin
      d = (i == 16) ? 16'hBEEF : (i == 3) ? 16'h00FF : 16'($urandom);
      cycle(1'b0, 1'b1, 16'(i), d);
      idle(1);
    end

    // Array survives reset; first read right after release
    do_reset();
    cycle(1'b1, 1'b0, 16'h0010, 16'h0000);
    idle(2);
    check("beef_dvalid", 16'(DValid), 16'h0001);
    check("beef_data", DataOut, 16'hBEEF);

    // Forward from buffer, then drain on the idle cycle
    cycle(1'b0, 1'b1, 16'h0005, 16'h1234);
    cycle(1'b1, 1'b0, 16'h0005, 16'h0000);
    idle(1);
    check("fwd_busy", 16'(Busy), 16'h0000);
    check("fwd_array", dut.mem_array[5], 16'h1234);
    idle(1);
    check("fwd_data", DataOut, 16'h1234);

    // Youngest match wins
    cycle(1'b0, 1'b1, 16'h0007, 16'hAAAA);
    cycle(1'b0, 1'b1, 16'h0007, 16'h5555);
    cycle(1'b1, 1'b0, 16'h0007, 16'h0000);
    idle(2);
    check("youngest_data", DataOut, 16'h5555);
    idle(3);

    // Illegal RD&WR: read served, write dropped
    cycle(1'b1, 1'b1, 16'h0003, 16'h9999);
    check("illegal_err", 16'(Err), 16'h0001);
    idle(2);
    check("illegal_data", DataOut, 16'h00FF);
    check("illegal_array", dut.mem_array[3], 16'h00FF);

    // Fill the buffer, then a write with RD high on a full buffer is dropped
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 16'(32 + i), 16'($urandom));
    cycle(1'b1, 1'b1, 16'h0024, 16'h7777);
    check("ovf_set", 16'(Ovf), 16'h0001);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 16'(32 + i), 16'h0000);
    idle(6);
    cycle(1'b1, 1'b0, 16'h0024, 16'h0000);
    idle(3);

    // Reset with buffered writes and reads in flight
    cycle(1'b0, 1'b1, 16'h0008, 16'hA008);
    cycle(1'b0, 1'b1, 16'h0009, 16'hA009);
    cycle(1'b0, 1'b1, 16'h000A, 16'hA00A);
    cycle(1'b1, 1'b0, 16'h0001, 16'h0000);
    cycle(1'b1, 1'b0, 16'h0002, 16'h0000);
    do_reset();
    idle(4);
    check("midrst_busy", 16'(Busy), 16'h0000);
    check("midrst_arr8", dut.mem_array[8], m_mem[8]);
    check("midrst_arr9", dut.mem_array[9], m_mem[9]);
    check("midrst_arr10", dut.mem_array[10], m_mem[10]);

    // Random traffic over 64 words with aliased upper address bits
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 99));
      a = 16'($urandom_range(0, 63)) | (16'($urandom_range(0, 63)) << 10);
      cycle((r < 35) || (r >= 97), ((r >= 35) && (r < 75)) || (r >= 97), a, 16'($urandom));
    end
    idle(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
